// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS instruction fetch unit:
//   RESET_VECTOR_DEFAULT : first fetch address after reset (boot ROM)
//   HALT_ADDRESS         : reaching this PC stops the CPU
//   fetch_state_e        : fetch FSM states
//   word_align()         : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDRESS         = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,  // sequential fetch
    SLOT   = 2'd1,  // fetching the branch delay slot; target is pending
    HALTED = 2'd2   // PC parked at HALT_ADDRESS until reset
  } fetch_state_e;

  // Instructions are word aligned; a misaligned target is rounded down.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit_if
// Bundles the decoder handshake, instruction-memory bus and status outputs of
// the fetch unit.
//   master : the fetch unit (drives address, instruction and status)
//   slave  : decoder + instruction memory (drives stall, redirect, read data)
// Signals:
//   stall, redirect_valid, redirect_target  decoder -> fetch
//   instr_address / instr_readdata          fetch <-> combinational memory
//   instr_out, pc_out, instr_valid          fetched instruction to decoder
//   in_delay_slot, active                   status
// -----------------------------------------------------------------------------
interface mips_fetch_unit_if;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        in_delay_slot;
  logic        active;

  modport master (
    input  stall, redirect_valid, redirect_target, instr_readdata,
    output instr_address, instr_out, pc_out, instr_valid, in_delay_slot, active
  );

  modport slave (
    output stall, redirect_valid, redirect_target, instr_readdata,
    input  instr_address, instr_out, pc_out, instr_valid, in_delay_slot, active
  );

endinterface

// File: rtl/mips_pc_reg.sv
// -----------------------------------------------------------------------------
// mips_pc_reg
// Program-counter register: WIDTH-bit register with asynchronous active-high
// reset to RESET_VALUE and a load enable (hold when i_en is low).
// Ports:
//   clk, reset : clock, async active-high reset
//   i_en       : load i_d on the next rising edge
//   i_d        : next value
//   o_q        : current value
// -----------------------------------------------------------------------------
module mips_pc_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
// MIPS instruction fetch with one branch delay slot. The PC drives the
// combinational instruction memory directly, so the instruction for the
// current PC is presented in the same cycle. A taken redirect is captured in
// RUN, the delay slot (PC+4) is fetched in SLOT, then the PC jumps to the
// captured target. Reaching address 0 halts the unit until reset.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : mips_fetch_unit_if.master (decoder handshake, memory, status)
// Parameters:
//   RESET_VECTOR : first fetch address after reset
// -----------------------------------------------------------------------------
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_fetch_unit_if.master      bus
);

  fetch_state_e r_state;
  logic [31:0]  r_target;
  logic         r_active;
  logic         r_in_slot;

  logic [31:0]  w_pc;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_pc_next;
  logic         w_pc_en;
  logic         w_halt_next;
  logic         w_instr_valid;

  // 32-bit add wraps naturally: FFFFFFFC + 4 = 0, which triggers the halt.
  assign w_pc_plus4 = w_pc + INSTR_BYTES;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    w_pc_next = w_pc_plus4;
    unique case (r_state)
      RUN:     w_pc_next = w_pc_plus4;
      SLOT:    w_pc_next = r_target;
      HALTED:  w_pc_next = HALT_ADDRESS;
      default: w_pc_next = w_pc_plus4;
    endcase
  end

  assign w_halt_next = (w_pc_next == HALT_ADDRESS);
  // Stall freezes everything; HALTED ignores all inputs.
  assign w_pc_en     = ~bus.stall & (r_state != HALTED);

  mips_pc_reg #(
    .WIDTH       (32),
    .RESET_VALUE (RESET_VECTOR)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_pc_en),
    .i_d   (w_pc_next),
    .o_q   (w_pc)
  );

  // Fetch FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_target  <= '0;
      r_active  <= 1'b1;
      r_in_slot <= 1'b0;
    end else if (w_pc_en) begin
      if (w_halt_next) begin
        // Halt takes precedence: a redirect arriving as PC+4 wraps is dropped.
        r_state   <= HALTED;
        r_active  <= 1'b0;
        r_in_slot <= 1'b0;
      end else begin
        unique case (r_state)
          RUN: begin
            if (bus.redirect_valid) begin
              r_target  <= word_align(bus.redirect_target);
              r_state   <= SLOT;
              r_in_slot <= 1'b1;
            end
          end
          SLOT: begin
            // redirect_valid is ignored while the delay slot is fetched.
            r_state   <= RUN;
            r_in_slot <= 1'b0;
          end
          default: begin
            r_state   <= r_state;
          end
        endcase
      end
    end
  end

  // Valid is masked by reset directly so the reset-vector fetch is live in
  // the very first cycle after release.
  assign w_instr_valid     = r_active & ~reset;

  assign bus.instr_address = w_pc;
  assign bus.pc_out        = w_pc;
  assign bus.instr_valid   = w_instr_valid;
  assign bus.instr_out     = w_instr_valid ? bus.instr_readdata : 32'h0;
  assign bus.in_delay_slot = r_in_slot;
  assign bus.active        = r_active;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_fetch_unit
// Directed testbench for mips_fetch_unit. Inputs change 1 ns after the rising
// edge and outputs are sampled there. The observed tuple is
// {instr_address, in_delay_slot, instr_valid, active}.
// -----------------------------------------------------------------------------
module tb_mips_fetch_unit;

  localparam logic [31:0] MEM_WORD = 32'h2402_0005;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mips_fetch_unit_if bus ();

  mips_fetch_unit #(
    .RESET_VECTOR (32'hBFC0_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [34:0] obs;
  logic [34:0] exp_v;
  assign obs = {bus.instr_address, bus.in_delay_slot, bus.instr_valid, bus.active};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.instr_readdata  = MEM_WORD;
    #3;
    exp_v = {32'hBFC0_0000, 3'b001};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_state got %h want %h", obs, exp_v); end
    n_checks++;
    if (bus.instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr_out got %h want 0", bus.instr_out); end
    step();
    step();
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_held got %h want %h", obs, exp_v); end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    #1;
    exp_v = {32'hBFC0_0000, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fetch_0 got %h want %h", obs, exp_v); end
    n_checks++;
    if (bus.instr_out !== MEM_WORD || bus.pc_out !== 32'hBFC0_0000) begin
      n_fail++; $display("FAIL fetch_0_out got instr %h pc %h want %h %h", bus.instr_out, bus.pc_out, MEM_WORD, 32'hBFC0_0000);
    end
    step();
    exp_v = {32'hBFC0_0004, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fetch_4 got %h want %h", obs, exp_v); end
    step();
    exp_v = {32'hBFC0_0008, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL fetch_8 got %h want %h", obs, exp_v); end
    n_checks++;
    if (bus.pc_out !== 32'hBFC0_0008) begin n_fail++; $display("FAIL fetch_8_pc_out got %h want bfc00008", bus.pc_out); end
  endtask

  // Continues from PC = BFC00008 left by test_fetch.
  task automatic test_redirect();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hBFC0_0100;
    step();
    exp_v = {32'hBFC0_000C, 3'b111};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL redir_slot got %h want %h", obs, exp_v); end
    // A second request during the slot must be ignored.
    bus.redirect_target = 32'hBFC0_0200;
    step();
    exp_v = {32'hBFC0_0100, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL redir_target got %h want %h", obs, exp_v); end
    // Misaligned target is rounded down to a word boundary.
    bus.redirect_target = 32'hBFC0_0403;
    step();
    exp_v = {32'hBFC0_0104, 3'b111};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL misalign_slot got %h want %h", obs, exp_v); end
    bus.redirect_valid = 1'b0;
    step();
    exp_v = {32'hBFC0_0400, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL misalign_target got %h want %h", obs, exp_v); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    exp_v = {32'hBFC0_0010, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL stall_pre got %h want %h", obs, exp_v); end
    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hBFC0_0300;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL stall_hold%0d got %h want %h", i, obs, exp_v); end
    end
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    exp_v = {32'hBFC0_0014, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL stall_release got %h want %h", obs, exp_v); end
    step();
    exp_v = {32'hBFC0_0018, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL stall_no_capture got %h want %h", obs, exp_v); end
  endtask

  task automatic test_halt();
    do_reset();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0;
    step();
    exp_v = {32'hBFC0_0004, 3'b111};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL halt_slot got %h want %h", obs, exp_v); end
    bus.redirect_valid = 1'b0;
    step();
    exp_v = {32'h0, 3'b000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL halt_enter got %h want %h", obs, exp_v); end
    for (int i = 0; i < 10; i++) begin
      bus.stall           = 1'($urandom);
      bus.redirect_valid  = 1'($urandom);
      bus.redirect_target = $urandom;
      step();
      n_checks++;
      if (obs !== exp_v || bus.instr_out !== 32'h0) begin
        n_fail++; $display("FAIL halt_hold%0d got %h instr %h want %h instr 0", i, obs, bus.instr_out, exp_v);
      end
    end
    // Reset out of HALTED restarts at the reset vector.
    do_reset();
    step();
    exp_v = {32'hBFC0_0004, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL halt_restart got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_slot();
    do_reset();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hBFC0_0500;
    step();
    exp_v = {32'hBFC0_0004, 3'b111};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_slot_pre got %h want %h", obs, exp_v); end
    bus.redirect_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    exp_v = {32'hBFC0_0000, 3'b001};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_slot_async got %h want %h", obs, exp_v); end
    reset = 1'b0;
    #1;
    exp_v = {32'hBFC0_0000, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_slot_release got %h want %h", obs, exp_v); end
    step();
    exp_v = {32'hBFC0_0004, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_slot_seq4 got %h want %h", obs, exp_v); end
    step();
    exp_v = {32'hBFC0_0008, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_slot_seq8 got %h want %h", obs, exp_v); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFF8;
    step();
    bus.redirect_valid = 1'b0;
    step();
    exp_v = {32'hFFFF_FFF8, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_f8 got %h want %h", obs, exp_v); end
    step();
    exp_v = {32'hFFFF_FFFC, 3'b011};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_fc got %h want %h", obs, exp_v); end
    step();
    exp_v = {32'h0, 3'b000};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_halt got %h want %h", obs, exp_v); end
    step();
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_halt_hold got %h want %h", obs, exp_v); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fetch();
    test_redirect();
    test_stall();
    test_halt();
    test_reset_mid_slot();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC00000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  high: hold PC, FSM and captured redirect; no state update.
REQ-005 redirect_valid  input  1  branch/jump taken by the decoder, qualified by stall low.
REQ-006 redirect_target  input  32  byte address of the taken branch/jump.
REQ-007 instr_address  output  32  fetch address to instruction memory; equals PC.
REQ-008 instr_readdata  input  32  combinational memory read data for instr_address, valid in the same cycle.
REQ-009 instr_out  output  32  fetched instruction; equals instr_readdata when instr_valid is high, else 0.
REQ-010 pc_out  output  32  address of instr_out.
REQ-011 instr_valid  output  1  instr_out/pc_out hold a live instruction this cycle.
REQ-012 in_delay_slot  output  1  the current instruction is a branch delay slot.
REQ-013 active  output  1  high until the CPU halts.

Function
REQ-014 FSM states: RUN, SLOT, HALTED.
REQ-015 RUN, stall low, redirect_valid low: PC <= PC+4, stay in RUN.
REQ-016 RUN, stall low, redirect_valid high: capture redirect_target, PC <= PC+4, go to SLOT.
REQ-017 SLOT, stall low: PC <= captured target, go to RUN; redirect_valid is ignored in this state.
REQ-018 Any state, stall high: PC, state and captured target are unchanged, and outputs are stable.
REQ-019 PC arithmetic is 32-bit modulo; PC+4 from 32'hFFFFFFFC yields 0.
REQ-020 When the next PC value is 0 (by redirect or wrap), PC <= 0 and the FSM goes to HALTED on that edge.
REQ-021 HALTED: PC is held at 0; active = 0; instr_valid = 0; inputs are ignored until reset.
REQ-022 in_delay_slot = 1 exactly while in SLOT.
REQ-023 instr_address and PC change only on a clock edge, giving zero-cycle fetch latency against the combinational memory.
REQ-024 Misaligned redirect_target (bits [1:0] != 0): bits [1:0] are forced to 0 on capture.
REQ-025 When stall and redirect_valid are high together, the redirect is not captured; the decoder holds the request until stall falls.

Reset
REQ-026 Asserting reset immediately (asynchronously) sets PC = RESET_VECTOR, state = RUN, captured target = 0, active = 1, and instr_valid = 0 while reset is high.
REQ-027 instr_valid = 1 from the first cycle after reset deassertion while in RUN or SLOT.
REQ-028 Reset during SLOT or HALTED discards the pending redirect and restarts at RESET_VECTOR.

Structure
REQ-029 Shared package mips_pkg holds RESET_VECTOR_DEFAULT, HALT_ADDRESS (32'h0) and the fetch state enum type.
REQ-030 Sub-module mips_pc_reg (32-bit register with async reset to a parameter value and a hold enable) holds the PC; the FSM and target capture live in mips_fetch_unit.

Verification
REQ-031 Reset release, no stall, memory returning 32'h24020005 -> instr_address is BFC00000, BFC00004, BFC00008 on successive cycles, instr_valid = 1 throughout.
REQ-032 Redirect_valid=1, target=BFC00100 while PC=BFC00008 -> next PC BFC0000C with in_delay_slot=1, then BFC00100 with in_delay_slot=0.
REQ-033 Stall high 3 cycles at PC=BFC00010 -> PC held for 3 cycles; a concurrent redirect is not captured; after stall drops PC=BFC00014.
REQ-034 Redirect to 32'h0 -> after delay slot PC=0, active=0, instr_valid=0; 10 further cycles with random inputs -> no change.
REQ-035 Reset asserted mid-SLOT (target captured) -> PC=BFC00000 without waiting for a clock edge; after release the sequence continues from BFC00004 with no jump to the old target.
REQ-036 PC forced near wrap (redirect to FFFFFFF8) -> FFFFFFF8, FFFFFFFC, then 0 and HALTED.
